ssd_scan_ctrl: RTL
==================

# ssd_scan_ctrl

Time-multiplexed scan controller for the 4-digit seven-segment display. It holds a double-buffered 4-digit BCD value and sequences one digit at a time onto the shared display: a one-hot digit enable plus one BCD nibble and a blanking strobe for the downstream BCD-to-7-segment decoder. It inserts dead time between digits to prevent ghosting. New values are swapped in only on frame boundaries, so the display never tears.

## Interface
Parameters:
- DIV, 50000, clock cycles per digit slot; must be ≥ 2.
- DEAD, 500, blank cycles at the start of each slot; 0 ≤ DEAD < DIV.

Ports:
- Clk  input  1  system clock; everything is on its rising edge.
- Aclr  input  1  asynchronous active-high reset.
- en  input  1  scan enable; low forces IDLE.
- ld_valid  input  1  new display value offered.
- ld_data  input  16  4 BCD digits; [15:12] goes to DG[1] (most significant), [3:0] goes to DG[4].
- ld_ready  output  1  high when the shadow buffer is free.
- DG  output  [1:4]  one-hot digit enable, active-high; all zero means no digit lit.
- bcd  output  4  BCD nibble of the lit digit.
- bi_n  output  1  blanking to the decoder, active-low (0 = segments off).
- frame_done  output  1  one-cycle pulse at the end of the digit-4 slot.

## Operation
- Registers: `active[15:0]`, `shadow[15:0]`, `pending`, `idx[1:0]`, `cnt`, `state ∈ {IDLE, BLANK, SHOW}`.
- Reset values:
  - `active` = 0, `shadow` = 0, `pending` = 0, `idx` = 0, `cnt` = 0, state = IDLE.
  - DG = 0, bcd = 0, bi_n = 0, ld_ready = 1, frame_done = 0.
- Load handshake:
  - Transfer occurs when ld_valid && ld_ready: `shadow` ← ld_data, `pending` ← 1.
  - ld_ready = !pending.
  - ld_valid while ld_ready = 0 is ignored; the source holds it.
- Frame swap:
  - At the last cycle of the idx=3 slot, if `pending` was set before that edge: `active` ← `shadow`, `pending` ← 0.
  - A load accepted on that same edge waits for the next frame end.
- IDLE:
  - DG = 0, bi_n = 0, `idx` and `cnt` held at 0.
  - If `pending`, swap on the next edge.
  - If en = 1, go to BLANK (or to SHOW when DEAD = 0).
- BLANK:
  - DG = 0, bi_n = 0, bcd = the current digit.
  - After DEAD cycles, go to SHOW.
- SHOW:
  - DG[idx+1] = 1, bcd = `active` nibble for `idx`, bi_n = 1 unless suppressed (see Configuration).
  - On slot end (`cnt` = DIV−1): `cnt` ← 0, `idx` ← `idx`+1 (wraps 3→0), next state BLANK (or SHOW when DEAD = 0).
  - frame_done = 1 for the slot-end cycle when `idx` = 3.
- en low in any state: go to IDLE on the next edge; `idx`/`cnt` clear; `shadow`/`pending` are kept.
- Nibbles > 9 pass through unchanged; the decoder blanks them.

## Timing
- All outputs are driven from flops and change only on Clk edges (or on Aclr).
- Slot length is exactly DIV cycles: DEAD blank cycles, then DIV−DEAD lit cycles. Frame = 4·DIV cycles.
- en sampled high at edge t:
  - DG[1] rises at edge t+DEAD+1.
  - DG[1] falls at edge t+DIV+1.
  - DG[2] rises at edge t+DIV+DEAD+1.
- ld_ready falls on the edge after acceptance.
- ld_ready rises on the edge that performs the swap. The new value is lit from the next slot's SHOW.
- Aclr mid-frame: immediate return to reset values. A pending load is discarded.

## Configuration
- SSD_LZB_EN defined: leading-zero blanking.
  - During SHOW of digit k (1–3), bi_n = 0 if that digit's nibble and all more-significant nibbles are 0.
  - DG[4] is never suppressed. DG still steps normally.
  - The suppress mask is computed from `active` only.
- Undefined: bi_n = 1 throughout SHOW; zeros display as "0".

## Structure
- Package `ssd_pkg`:
  - state enum (IDLE, BLANK, SHOW).
  - NUM_DIG = 4.
  - function idx→one-hot DG.
  - function returning the leading-zero mask from a 16-bit value.
- Sub-module `ssd_slot_timer`:
  - Owns `cnt`/`idx`.
  - Outputs `dead_end`, `slot_end`, `frame_end`.
  - Clears on `clr` (= !en).
- Top-level FSM, buffers and output registers live in `ssd_scan_ctrl`.

## Test plan
All scenarios use DIV=8, DEAD=2.
- Reset, then en=1, load 16'h1234 while idle → DG steps 1000, 0100, 0010, 0001. bcd = 1, 2, 3, 4. Each lit 6 cycles, preceded by 2 cycles of DG=0. frame_done every 32 cycles.
- Mid-frame load 16'h5678 while showing digit 2 → digits 2–4 still show 2, 3, 4. ld_ready=0 until frame end. Next frame shows 5, 6, 7, 8.
- Second ld_valid while pending → ignored; after the swap ld_ready=1 and the second load is accepted; it shows one frame later.
- Load accepted on the same cycle as frame_done → swap happens at the following frame_done, not this one.
- en dropped during digit 3 → DG=0, bi_n=0 next cycle. Re-enable → restart at DG[1] after 2 blank cycles. A pending load is swapped while IDLE.
- With SSD_LZB_EN, load 16'h0040 → bi_n=0 on digits 1–2, bi_n=1 with bcd=4 on digit 3, bi_n=1 with bcd=0 on digit 4. Aclr asserted mid-scan → all outputs at reset values immediately.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// Digit index 0 is the most significant digit (DG[1], ld_data[15:12]).
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam int NUM_DIG = 4;
    localparam int IDX_W   = $clog2(NUM_DIG);

    function automatic logic [1:4] dg_onehot(input logic [IDX_W-1:0] idx);
        logic [1:4] r;
        r = '0;
        case (idx)
            2'd0: r[1] = 1'b1;
            2'd1: r[2] = 1'b1;
            2'd2: r[3] = 1'b1;
            2'd3: r[4] = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] nibble_of(input logic [15:0] v, input logic [IDX_W-1:0] idx);
        logic [3:0] r;
        case (idx)
            2'd0: r = v[15:12];
            2'd1: r = v[11:8];
            2'd2: r = v[7:4];
            2'd3: r = v[3:0];
        endcase
        return r;
    endfunction

    // Bit i set: digit i and every more-significant digit are zero.
    // The least significant digit is never suppressed.
    function automatic logic [NUM_DIG-1:0] lz_mask(input logic [15:0] v);
        logic [NUM_DIG-1:0] m;
        m[0] = (v[15:12] == 4'd0);
        m[1] = m[0] && (v[11:8] == 4'd0);
        m[2] = m[1] && (v[7:4] == 4'd0);
        m[3] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/ssd_slot_timer.sv
// Slot/digit counter for the scan controller: counts DIV cycles per slot
// and steps the digit index, flagging the end of the dead time and of the slot.
module ssd_slot_timer
    import ssd_pkg::*;
#(
    parameter int DIV  = 50000,
    parameter int DEAD = 500
) (
    input  logic             Clk,
    input  logic             Aclr,
    input  logic             clr,
    input  logic             run,
    output logic [IDX_W-1:0] idx,
    output logic             dead_end,
    output logic             slot_end,
    output logic             frame_end
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = (DEAD > 0) ? CW'(DEAD - 1) : '0;

    logic [CW-1:0] cnt;

    assign slot_end  = (cnt == SLOT_LAST);
    assign dead_end  = (DEAD > 0) && (cnt == DEAD_LAST);
    assign frame_end = slot_end && (idx == IDX_W'(NUM_DIG - 1));

    always_ff @(posedge Clk or posedge Aclr) begin
        if (Aclr) begin
            cnt <= '0;
            idx <= '0;
        end else if (clr) begin
            cnt <= '0;
            idx <= '0;
        end else if (run) begin
            if (slot_end) begin
                cnt <= '0;
                idx <= idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scan controller with double-buffered BCD value,
// dead time between digits and tear-free swaps on frame boundaries.
// Define SSD_LZB_EN to enable leading-zero blanking.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int DIV  = 50000,
    parameter int DEAD = 500
) (
    input  logic        Clk,
    input  logic        Aclr,
    input  logic        en,
    input  logic        ld_valid,
    input  logic [15:0] ld_data,
    output logic        ld_ready,
    output logic [1:4]  DG,
    output logic [3:0]  bcd,
    output logic        bi_n,
    output logic        frame_done,
    output logic [1:0]  state_dbg
);

    // Load handshake: a word moves when ld_valid && ld_ready at a rising edge;
    // the source keeps ld_valid/ld_data stable until then. ld_ready == !pending.

    state_t             state;
    logic [15:0]        active;
    logic [15:0]        shadow;
    logic               pending;
    logic [IDX_W-1:0]   idx;
    logic               dead_end;
    logic               slot_end;
    logic               frame_end;
    logic               accept;
    logic               do_swap;
    logic [NUM_DIG-1:0] lz_m;
    logic               suppress;

    ssd_slot_timer #(
        .DIV  (DIV),
        .DEAD (DEAD)
    ) u_timer (
        .Clk       (Clk),
        .Aclr      (Aclr),
        .clr       (!en),
        .run       (state != IDLE),
        .idx       (idx),
        .dead_end  (dead_end),
        .slot_end  (slot_end),
        .frame_end (frame_end)
    );

`ifdef SSD_LZB_EN
    assign lz_m = lz_mask(active);
`else
    assign lz_m = '0;
`endif
    assign suppress = lz_m[idx];

    assign accept    = ld_valid && ld_ready;
    assign do_swap   = pending && ((state == IDLE) || ((state == SHOW) && frame_end));
    assign state_dbg = state;

    always_ff @(posedge Clk or posedge Aclr) begin
        if (Aclr) begin
            state      <= IDLE;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            ld_ready   <= 1'b1;
            DG         <= '0;
            bcd        <= '0;
            bi_n       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // Swap and accept are exclusive: accept needs !pending, swap needs pending.
            if (do_swap) begin
                active   <= shadow;
                pending  <= 1'b0;
                ld_ready <= 1'b1;
            end else if (accept) begin
                shadow   <= ld_data;
                pending  <= 1'b1;
                ld_ready <= 1'b0;
            end

            // Display registers trail the state by one cycle; en gates them so
            // the display goes dark on the same edge that sees en low.
            DG         <= (en && state == SHOW) ? dg_onehot(idx) : '0;
            bcd        <= nibble_of(active, idx);
            bi_n       <= en && (state == SHOW) && !suppress;
            frame_done <= en && (state == SHOW) && frame_end;

            if (!en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:    state <= (DEAD == 0) ? SHOW : BLANK;
                    BLANK:   if (dead_end) state <= SHOW;
                    SHOW:    if (slot_end) state <= (DEAD == 0) ? SHOW : BLANK;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
